acc_multi_top: RTL and testbench

ACC_MULTI_TOP -- requirements
Module: acc_multi_top

---
 rtl/acc_multi_pkg.sv | 25 ++
 rtl/acc_channel.sv | 91 +++++++++
 rtl/acc_multi_top.sv | 61 ++++++
 tb/tb_acc_multi_top.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_multi_pkg.sv
// Shared definitions for the multi-channel accelerator: channel state
// encodings, default parameter values and a small population-count helper.
package acc_multi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WORK = 3'b010,
    ST_ACK  = 3'b100
  } ch_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_DONE_W = 16;

  // Number of set bits in a vector of up to 16 channel flags.
  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/acc_channel.sv
// One accelerator channel: a 4-phase request/acknowledge FSM with a work
// counter that runs from 0 up to the latched length N, plus an abort path.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; counter held at 0
//   WORK  | counting up to latched N; abort sends the run to ACK early
//   ACK   | finish held high until start drops; aborted flag held
module acc_channel
  import acc_multi_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] ncycles,
  output logic             finish,
  output logic             aborted,
  output logic             busy,
  output logic             enter_ack
);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_lat;

  // Flags the edge on which this channel moves from WORK into ACK, so the
  // top level can count completions on that same edge.
  assign enter_ack = !reset && (state == ST_WORK) && (abort || (cnt == n_lat));

  // Channel FSM with registered status outputs. The terminal compare happens
  // before the increment, so N = 2^CNT_W-1 finishes without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      n_lat   <= '0;
      finish  <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          finish  <= 1'b0;
          aborted <= 1'b0;
          if (start) begin
            n_lat <= ncycles;
            state <= ST_WORK;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WORK: begin
          if (abort) begin
            state   <= ST_ACK;
            finish  <= 1'b1;
            aborted <= 1'b1;
            busy    <= 1'b0;
          end else if (cnt == n_lat) begin
            state   <= ST_ACK;
            finish  <= 1'b1;
            aborted <= 1'b0;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          busy <= 1'b0;
          if (!start) begin
            state   <= ST_IDLE;
            finish  <= 1'b0;
            aborted <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          finish  <= 1'b0;
          aborted <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/acc_multi_top.sv
// Multi-channel accelerator: NUM_CH independent acc_channel instances and a
// shared completion counter that adds every channel entering ACK per edge.
module acc_multi_top
  import acc_multi_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DONE_W = DEF_DONE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH*CNT_W-1:0] i_ncycles,
  input  logic [NUM_CH-1:0]       i_abort,
  output logic [NUM_CH-1:0]       o_finish,
  output logic [NUM_CH-1:0]       o_aborted,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [DONE_W-1:0]       o_done_cnt
);

  // One extra bit over the wider of the counter and the per-edge increment,
  // so the sum never drops a carry before it is truncated back to DONE_W.
  localparam int SUM_W = ((DONE_W > 5) ? DONE_W : 5) + 1;

  logic [NUM_CH-1:0] enter_ack;
  logic [15:0]       ack_vec;
  logic [4:0]        n_enter;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      acc_channel #(
        .CNT_W(CNT_W)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .start    (i_start[k]),
        .abort    (i_abort[k]),
        .ncycles  (i_ncycles[k*CNT_W +: CNT_W]),
        .finish   (o_finish[k]),
        .aborted  (o_aborted[k]),
        .busy     (o_busy[k]),
        .enter_ack(enter_ack[k])
      );
    end
  endgenerate

  assign ack_vec = 16'(enter_ack);
  assign n_enter = count_ones(ack_vec);

  // Completion counter; simultaneous completions are all added on one edge
  // and the total wraps modulo 2^DONE_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_done_cnt <= '0;
    end else begin
      o_done_cnt <= DONE_W'(SUM_W'(o_done_cnt) + SUM_W'(n_enter));
    end
  end

endmodule

// File: tb/tb_acc_multi_top.sv
// Bench for acc_multi_top: a wide instance (CNT_W=32, DONE_W=16) and a narrow
// one (CNT_W=8, DONE_W=2), a deadline-based reference model checked every
// cycle, and directed scenarios with literal expected values.
module tb_acc_multi_top;

  logic clk = 1'b0;
  logic reset;

  logic [3:0]   st_a, ab_a, fin_a, abd_a, bsy_a;
  logic [127:0] nc_a;
  logic [15:0]  dc_a;

  logic [3:0]   st_b, ab_b, fin_b, abd_b, bsy_b;
  logic [31:0]  nc_b;
  logic [1:0]   dc_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  acc_multi_top #(.NUM_CH(4), .CNT_W(32), .DONE_W(16)) dut_a (
    .clk(clk), .reset(reset), .i_start(st_a), .i_ncycles(nc_a), .i_abort(ab_a),
    .o_finish(fin_a), .o_aborted(abd_a), .o_busy(bsy_a), .o_done_cnt(dc_a)
  );

  acc_multi_top #(.NUM_CH(4), .CNT_W(8), .DONE_W(2)) dut_b (
    .clk(clk), .reset(reset), .i_start(st_b), .i_ncycles(nc_b), .i_abort(ab_b),
    .o_finish(fin_b), .o_aborted(abd_b), .o_busy(bsy_b), .o_done_cnt(dc_b)
  );

  // Reference model: phase 0=idle 1=work 2=ack; a run started on edge c
  // completes on edge c+N+1 unless an abort is sampled while working.
  longint cyc = 0;
  int     m_ph [2][4];
  longint m_dl [2][4];
  bit     m_ab [2][4];
  longint m_done [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      for (int k = 0; k < 4; k++) begin
        m_ph[i][k] = 0; m_dl[i][k] = 0; m_ab[i][k] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int entered;
      entered = 0;
      for (int k = 0; k < 4; k++) begin
        logic   s, a;
        longint n;
        s = (i == 0) ? st_a[k] : st_b[k];
        a = (i == 0) ? ab_a[k] : ab_b[k];
        n = (i == 0) ? longint'(nc_a[k*32 +: 32]) : longint'(nc_b[k*8 +: 8]);
        if (reset) begin
          m_ph[i][k] = 0;
          m_ab[i][k] = 1'b0;
        end else if (m_ph[i][k] == 0) begin
          if (s) begin
            m_ph[i][k] = 1;
            m_dl[i][k] = cyc + n + 1;
          end
        end else if (m_ph[i][k] == 1) begin
          if (a || cyc == m_dl[i][k]) begin
            m_ph[i][k] = 2;
            m_ab[i][k] = a;
            entered++;
          end
        end else begin
          if (!s) begin
            m_ph[i][k] = 0;
            m_ab[i][k] = 1'b0;
          end
        end
      end
      m_done[i] = reset ? 0 : m_done[i] + entered;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_fin(input int i, input int k);
    return (i == 0) ? fin_a[k] : fin_b[k];
  endfunction
  function automatic logic get_abd(input int i, input int k);
    return (i == 0) ? abd_a[k] : abd_b[k];
  endfunction
  function automatic logic get_bsy(input int i, input int k);
    return (i == 0) ? bsy_a[k] : bsy_b[k];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("m%0d_fin%0d", i, k), get_fin(i, k), m_ph[i][k] == 2);
          check($sformatf("m%0d_abd%0d", i, k), get_abd(i, k), (m_ph[i][k] == 2) && m_ab[i][k]);
          check($sformatf("m%0d_bsy%0d", i, k), get_bsy(i, k), m_ph[i][k] == 1);
        end
      end
      check("m0_done", dc_a, m_done[0] % 65536);
      check("m1_done", dc_b, m_done[1] % 4);
    end
  end

  task automatic set_n(input int i, input int k, input longint n);
    if (i == 0) nc_a[k*32 +: 32] = n[31:0];
    else        nc_b[k*8 +: 8]   = n[7:0];
  endtask

  task automatic set_start(input int i, input int k, input logic v);
    if (i == 0) st_a[k] = v;
    else        st_b[k] = v;
  endtask

  task automatic set_abort(input int i, input int k, input logic v);
    if (i == 0) ab_a[k] = v;
    else        ab_b[k] = v;
  endtask

  // Called at a negedge with start already driven: waits for the sampling
  // edge, then counts edges until finish and samples of busy along the way.
  task automatic run_lat(input int i, input int k, output int lat, output int bn);
    @(posedge clk);
    lat = 0;
    bn  = 0;
    @(negedge clk);
    if (get_bsy(i, k)) bn++;
    while (!get_fin(i, k) && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_bsy(i, k)) bn++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn;
    reset = 1'b1;
    st_a = '0; ab_a = '0; nc_a = '0;
    st_b = '0; ab_b = '0; nc_b = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fin", fin_a, 0);
    check("rst_bsy", bsy_a, 0);
    check("rst_done", dc_a, 0);
    reset = 1'b0;

    // Ch0 N=5: 6-cycle latency, busy for 6 cycles, one completion.
    set_n(0, 0, 5); set_start(0, 0, 1'b1);
    run_lat(0, 0, lat, bn);
    check("n5_lat", lat, 6);
    check("n5_busy", bn, 6);
    check("n5_done", dc_a, 1);
    set_start(0, 0, 1'b0);
    @(negedge clk);
    check("n5_drop", fin_a[0], 0);

    // Ch1 N=0: single-cycle latency.
    set_n(0, 1, 0); set_start(0, 1, 1'b1);
    run_lat(0, 1, lat, bn);
    check("n0_lat", lat, 1);
    check("n0_done", dc_a, 2);
    set_start(0, 1, 1'b0);
    @(negedge clk);

    // Narrow instance, N=255 with CNT_W=8: 256 cycles, no overflow.
    set_n(1, 0, 255); set_start(1, 0, 1'b1);
    run_lat(1, 0, lat, bn);
    check("nmax_lat", lat, 256);
    check("nmax_done", dc_b, 1);
    set_start(1, 0, 1'b0);
    @(negedge clk);

    // Abort in IDLE is ignored.
    set_abort(0, 1, 1'b1);
    repeat (3) @(negedge clk);
    check("idle_abort_bsy", bsy_a[1], 0);
    set_abort(0, 1, 1'b0);

    // Ch2 N=100, abort sampled on edge 10.
    set_n(0, 2, 100); set_start(0, 2, 1'b1);
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    set_abort(0, 2, 1'b1);
    @(negedge clk);
    check("abort_fin", fin_a[2], 1);
    check("abort_flag", abd_a[2], 1);
    check("abort_done", dc_a, 3);
    set_abort(0, 2, 1'b0); set_start(0, 2, 1'b0);
    @(negedge clk);
    check("abort_clr", abd_a[2], 0);

    // Abort coincident with terminal count (N=3, edge 4).
    set_n(0, 2, 3); set_start(0, 2, 1'b1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_abort(0, 2, 1'b1);
    @(negedge clk);
    check("coinc_fin", fin_a[2], 1);
    check("coinc_flag", abd_a[2], 1);
    @(negedge clk);
    check("ack_abort_hold", abd_a[2], 1);
    set_abort(0, 2, 1'b0); set_start(0, 2, 1'b0);
    @(negedge clk);
    check("coinc_done", dc_a, 4);

    // All four channels N=7 together: one edge, done steps by 4.
    for (int k = 0; k < 4; k++) begin
      set_n(0, k, 7); set_start(0, k, 1'b1);
    end
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("all_pre_fin", fin_a, 0);
    check("all_pre_done", dc_a, 4);
    @(negedge clk);
    check("all_fin", fin_a, 15);
    check("all_done", dc_a, 8);
    st_a = '0;
    @(negedge clk);

    // Narrow done counter wraps: 1 -> 3 -> 0.
    set_n(1, 1, 1); set_n(1, 2, 1);
    set_start(1, 1, 1'b1); set_start(1, 2, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_3", dc_b, 3);
    set_start(1, 1, 1'b0); set_start(1, 2, 1'b0);
    set_n(1, 3, 0); set_start(1, 3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrap_fin", fin_b[3], 1);
    check("wrap_0", dc_b, 0);
    set_start(1, 3, 1'b0);
    @(negedge clk);

    // Reset in mid-WORK on ch3 (N=50, edge 20), start held high afterwards.
    set_n(0, 3, 50); set_start(0, 3, 1'b1);
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("pre_rst_bsy", bsy_a[3], 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_bsy", bsy_a, 0);
    check("rst_mid_fin", fin_a, 0);
    check("rst_mid_done", dc_a, 0);
    reset = 1'b0;
    run_lat(0, 3, lat, bn);
    check("rst_rerun_lat", lat, 51);
    check("rst_rerun_done", dc_a, 1);
    set_start(0, 3, 1'b0);
    @(negedge clk);

    // N changed after the latch edge; start held through ACK.
    set_n(0, 0, 4); set_start(0, 0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_n(0, 0, 20);
    lat = 0;
    while (!fin_a[0] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latch_lat", lat, 5);
    repeat (10) @(negedge clk);
    check("no_retrig_fin", fin_a[0], 1);
    check("no_retrig_bsy", bsy_a[0], 0);
    set_start(0, 0, 1'b0);
    @(negedge clk);
    check("relaunch_idle", fin_a[0], 0);
    set_start(0, 0, 1'b1);
    run_lat(0, 0, lat, bn);
    check("relaunch_lat", lat, 21);
    check("final_done", dc_a, 3);
    set_start(0, 0, 1'b0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
